// File: rtl/tile_sram_bank_if.sv
// Tile-side and host-side signal bundle for tile_sram_bank.
// master = tile_processor plus host driver; slave = the SRAM bank.
interface tile_sram_bank_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              tp_sram_A_we;
  logic              tp_sram_B_we;
  logic              tp_sram_C_we;
  logic [ADDR_W-1:0] tp_sram_A_addr;
  logic [ADDR_W-1:0] tp_sram_B_addr;
  logic [ADDR_W-1:0] tp_sram_C_addr;
  logic [DATA_W-1:0] tp_sram_A_din;
  logic [DATA_W-1:0] tp_sram_B_din;
  logic [DATA_W-1:0] tp_sram_C_din;
  logic [DATA_W-1:0] sram_A_dout;
  logic [DATA_W-1:0] sram_B_dout;
  logic              tp_busy;
  logic              host_req;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_err;

  modport master (
    output tp_sram_A_we, tp_sram_B_we, tp_sram_C_we,
    output tp_sram_A_addr, tp_sram_B_addr, tp_sram_C_addr,
    output tp_sram_A_din, tp_sram_B_din, tp_sram_C_din,
    output tp_busy, host_req, host_we, host_sel, host_addr, host_wdata,
    input  sram_A_dout, sram_B_dout, host_ack, host_rdata, host_err
  );

  modport slave (
    input  tp_sram_A_we, tp_sram_B_we, tp_sram_C_we,
    input  tp_sram_A_addr, tp_sram_B_addr, tp_sram_C_addr,
    input  tp_sram_A_din, tp_sram_B_din, tp_sram_C_din,
    input  tp_busy, host_req, host_we, host_sel, host_addr, host_wdata,
    output sram_A_dout, sram_B_dout, host_ack, host_rdata, host_err
  );
endinterface

// File: rtl/tile_sram_bank.sv
// A/B/C tile buffers: tile port (1-cycle reads, read-first) and host req/ack port gated by tp_busy.
// Optional even-parity protection enabled by defining TILE_SRAM_PARITY_EN.
module tile_sram_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  tile_sram_bank_if.slave bus
`ifdef TILE_SRAM_PARITY_EN
  ,
  output logic            parity_err
`endif
);

`ifdef TILE_SRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef TILE_SRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0] mem_a [DEPTH];
  logic [MEM_W-1:0] mem_b [DEPTH];
  logic [MEM_W-1:0] mem_c [DEPTH];

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_dout_q, a_dout_d;
  logic [DATA_W-1:0] b_dout_q, b_dout_d;
  logic [MEM_W-1:0]  host_word_c;
  logic              host_bad_c;
  logic              host_wr_c;

  assign host_bad_c = (sel_q == 2'd3) || !in_range(addr_q);
  assign host_wr_c  = (state_q == ACCESS) && we_q && !host_bad_c;

  // Host-side word selected by the latched request
  always_comb begin
    host_word_c = '0;
    case (sel_q)
      SEL_A:   host_word_c = mem_a[addr_q];
      SEL_B:   host_word_c = mem_b[addr_q];
      SEL_C:   host_word_c = mem_c[addr_q];
      default: host_word_c = '0;
    endcase
  end

  // Host FSM next state and registered response
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.host_req && !bus.tp_busy) begin
          we_d    = bus.host_we;
          sel_d   = bus.host_sel;
          addr_d  = bus.host_addr;
          wdata_d = bus.host_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = 1'b1;
        if (host_bad_c) begin
          err_d = 1'b1;
        end else if (!we_q) begin
          rdata_d = host_word_c[DATA_W-1:0];
`ifdef TILE_SRAM_PARITY_EN
          err_d   = ^host_word_c;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tile-side read data, zero outside the bank
  always_comb begin
    a_dout_d = '0;
    b_dout_d = '0;
    if (in_range(bus.tp_sram_A_addr)) a_dout_d = mem_a[bus.tp_sram_A_addr][DATA_W-1:0];
    if (in_range(bus.tp_sram_B_addr)) b_dout_d = mem_b[bus.tp_sram_B_addr][DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  // Tile write is issued last so it wins a same-address collision with the host
  always_ff @(posedge clk) begin
    if (host_wr_c && sel_q == SEL_A) mem_a[addr_q] <= encode(wdata_q);
    if (host_wr_c && sel_q == SEL_B) mem_b[addr_q] <= encode(wdata_q);
    if (host_wr_c && sel_q == SEL_C) mem_c[addr_q] <= encode(wdata_q);
    if (bus.tp_sram_A_we && in_range(bus.tp_sram_A_addr))
      mem_a[bus.tp_sram_A_addr] <= encode(bus.tp_sram_A_din);
    if (bus.tp_sram_B_we && in_range(bus.tp_sram_B_addr))
      mem_b[bus.tp_sram_B_addr] <= encode(bus.tp_sram_B_din);
    if (bus.tp_sram_C_we && in_range(bus.tp_sram_C_addr))
      mem_c[bus.tp_sram_C_addr] <= encode(bus.tp_sram_C_din);
  end

`ifdef TILE_SRAM_PARITY_EN
  logic par_err_q, par_err_d;

  // Sticky flag for tile-side reads of corrupted words
  always_comb begin
    par_err_d = par_err_q;
    if (in_range(bus.tp_sram_A_addr) && ^mem_a[bus.tp_sram_A_addr]) par_err_d = 1'b1;
    if (in_range(bus.tp_sram_B_addr) && ^mem_b[bus.tp_sram_B_addr]) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign parity_err = par_err_q;
`endif

  assign bus.sram_A_dout = a_dout_q;
  assign bus.sram_B_dout = b_dout_q;
  assign bus.host_ack    = ack_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_err    = err_q;

endmodule

// File: tb/tb_tile_sram_bank.sv
// Self-checking bench for tile_sram_bank: directed scenarios plus randomized host/tile traffic vs. an array model.
`timescale 1ns/1ps
module tb_tile_sram_bank;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m     [3][DEPTH];
  bit         known [3][DEPTH];

  tile_sram_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef TILE_SRAM_PARITY_EN
  logic parity_err;
`endif

  tile_sram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TILE_SRAM_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #10.582 clk = ~clk;

  task automatic idle_inputs();
    bus.tp_sram_A_we = 0; bus.tp_sram_B_we = 0; bus.tp_sram_C_we = 0;
    bus.tp_sram_A_addr = '0; bus.tp_sram_B_addr = '0; bus.tp_sram_C_addr = '0;
    bus.tp_sram_A_din = '0; bus.tp_sram_B_din = '0; bus.tp_sram_C_din = '0;
    bus.tp_busy = 0; bus.host_req = 0; bus.host_we = 0; bus.host_sel = '0;
    bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic model_write(input logic [1:0] sel, input logic [9:0] addr, input logic [7:0] d);
    if (sel != 2'd3) begin
      m[sel][addr] = d;
      known[sel][addr] = 1'b1;
    end
  endtask

  // Drive one host transaction; lat = cycles from request to ack, 0 on timeout
  task automatic host_op(input logic we, input logic [1:0] sel, input logic [9:0] addr,
                         input logic [7:0] wd, output logic [7:0] rd, output logic err,
                         output int lat);
    bus.host_req = 1; bus.host_we = we; bus.host_sel = sel;
    bus.host_addr = addr; bus.host_wdata = wd;
    lat = 0; rd = '0; err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.host_ack === 1'b1) begin
        lat = i; rd = bus.host_rdata; err = bus.host_err;
        break;
      end
    end
    bus.host_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    bus.host_req = 1; bus.host_sel = 2'd0; bus.host_addr = 10'h005;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.sram_A_dout, bus.sram_B_dout, bus.host_ack, bus.host_rdata} !== 25'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: A=%h B=%h ack=%b rdata=%h, want all 0",
                 i, bus.sram_A_dout, bus.sram_B_dout, bus.host_ack, bus.host_rdata);
      end
    end
    bus.host_req = 0;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_host_rw();
    logic [7:0] rd; logic err; int lat;
    host_op(1'b1, 2'd0, 10'h005, 8'h3C, rd, err, lat);
    model_write(2'd0, 10'h005, 8'h3C);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 8'h00) begin
      errors++;
      $display("FAIL host_write: lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=00", lat, err, rd);
    end
    host_op(1'b0, 2'd0, 10'h005, 8'h00, rd, err, lat);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 8'h3C) begin
      errors++;
      $display("FAIL host_read: lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=3c", lat, err, rd);
    end
  endtask

  task automatic test_tile_latency();
    logic [7:0] rd; logic err; int lat;
    host_op(1'b1, 2'd1, 10'h3FF, 8'hA7, rd, err, lat);
    model_write(2'd1, 10'h3FF, 8'hA7);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL load_b_latency: got %0d want 2", lat);
    end
    bus.tp_sram_B_addr = 10'h3FF;
    @(posedge clk); #1;
    checks++;
    if (bus.sram_B_dout !== 8'hA7) begin
      errors++;
      $display("FAIL tile_b_read: got %h want a7", bus.sram_B_dout);
    end
    // Tile write and read of the same word on one edge returns the old value
    bus.tp_sram_A_addr = 10'h005; bus.tp_sram_A_we = 1; bus.tp_sram_A_din = 8'h99;
    @(posedge clk); #1;
    bus.tp_sram_A_we = 0;
    checks++;
    if (bus.sram_A_dout !== m[0][5]) begin
      errors++;
      $display("FAIL tile_read_first: got %h want %h", bus.sram_A_dout, m[0][5]);
    end
    model_write(2'd0, 10'h005, 8'h99);
    @(posedge clk); #1;
    checks++;
    if (bus.sram_A_dout !== 8'h99) begin
      errors++;
      $display("FAIL tile_read_after_write: got %h want 99", bus.sram_A_dout);
    end
  endtask

  task automatic test_busy();
    int lat;
    bus.tp_busy = 1;
    bus.host_req = 1; bus.host_we = 0; bus.host_sel = 2'd2; bus.host_addr = 10'h010;
    bus.tp_sram_C_we = 1; bus.tp_sram_C_addr = 10'h010; bus.tp_sram_C_din = 8'h51;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.tp_sram_C_we = 0;
      checks++;
      if (bus.host_ack !== 1'b0) begin
        errors++;
        $display("FAIL busy_stall cyc%0d: ack=%b want 0", i, bus.host_ack);
      end
    end
    model_write(2'd2, 10'h010, 8'h51);
    bus.tp_busy = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.tp_busy = 1;   // busy rising after acceptance must not cancel the op
      if (bus.host_ack === 1'b1) begin
        lat = i;
        checks++;
        if (bus.host_rdata !== m[2][16] || bus.host_err !== 1'b0) begin
          errors++;
          $display("FAIL busy_result: rdata=%h err=%b want %h err=0", bus.host_rdata, bus.host_err, m[2][16]);
        end
        break;
      end
    end
    bus.host_req = 0;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL busy_release_latency: got %0d want 2", lat);
    end
    @(posedge clk); #1;
    bus.tp_busy = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    logic [7:0] rd; logic err; int lat;
    // Host write lands on the edge after acceptance; tile write to the same word on that edge
    bus.host_req = 1; bus.host_we = 1; bus.host_sel = 2'd0; bus.host_addr = 10'h007; bus.host_wdata = 8'h22;
    @(posedge clk); #1;
    bus.tp_sram_A_we = 1; bus.tp_sram_A_addr = 10'h007; bus.tp_sram_A_din = 8'h11;
    @(posedge clk); #1;
    bus.tp_sram_A_we = 0; bus.host_req = 0;
    checks++;
    if (bus.host_ack !== 1'b1) begin
      errors++;
      $display("FAIL collision_ack: ack=%b want 1", bus.host_ack);
    end
    model_write(2'd0, 10'h007, 8'h11);
    @(posedge clk); #1;
    host_op(1'b0, 2'd0, 10'h007, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'h11 || lat !== 2) begin
      errors++;
      $display("FAIL collision_tile_wins: rdata=%h lat=%0d want 11 lat=2", rd, lat);
    end
    // Host read racing a tile write sees the old word
    host_op(1'b1, 2'd0, 10'h009, 8'h5A, rd, err, lat);
    model_write(2'd0, 10'h009, 8'h5A);
    bus.host_req = 1; bus.host_we = 0; bus.host_sel = 2'd0; bus.host_addr = 10'h009;
    @(posedge clk); #1;
    bus.tp_sram_A_we = 1; bus.tp_sram_A_addr = 10'h009; bus.tp_sram_A_din = 8'hC3;
    @(posedge clk); #1;
    bus.tp_sram_A_we = 0; bus.host_req = 0;
    checks++;
    if (bus.host_ack !== 1'b1 || bus.host_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL read_collision_old: ack=%b rdata=%h want ack=1 rdata=5a", bus.host_ack, bus.host_rdata);
    end
    model_write(2'd0, 10'h009, 8'hC3);
    @(posedge clk); #1;
    host_op(1'b0, 2'd0, 10'h009, 8'h00, rd, err, lat);
    checks++;
    if (rd !== 8'hC3) begin
      errors++;
      $display("FAIL read_collision_after: rdata=%h want c3", rd);
    end
    host_op(1'b0, 2'd3, 10'h005, 8'h00, rd, err, lat);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL bad_select_read: lat=%0d err=%b rdata=%h want lat=2 err=1 rdata=00", lat, err, rd);
    end
    host_op(1'b1, 2'd3, 10'h005, 8'hEE, rd, err, lat);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL bad_select_write: lat=%0d err=%b rdata=%h want lat=2 err=1 rdata=00", lat, err, rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] rd; logic err; int lat;
    bus.host_req = 1; bus.host_we = 0; bus.host_sel = 2'd0; bus.host_addr = 10'h007;
    @(posedge clk); #1;
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.host_ack !== 1'b0) begin
        errors++;
        $display("FAIL midop_reset_noack cyc%0d: ack=%b want 0", i, bus.host_ack);
      end
    end
    bus.host_req = 0;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_after: ack=%b want 0", bus.host_ack);
    end
    host_op(1'b0, 2'd0, 10'h007, 8'h00, rd, err, lat);
    checks++;
    if (lat !== 2 || rd !== m[0][7]) begin
      errors++;
      $display("FAIL midop_reset_recover: lat=%0d rdata=%h want lat=2 rdata=%h", lat, rd, m[0][7]);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_ack;
    bus.host_req = 1; bus.host_we = 0; bus.host_sel = 2'd1; bus.host_addr = 10'h3FF;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 3 == 2);
      checks++;
      if (bus.host_ack !== exp_ack || (exp_ack && bus.host_rdata !== m[1][1023])) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: ack=%b rdata=%h want ack=%b rdata=%h",
                 i, bus.host_ack, bus.host_rdata, exp_ack, m[1][1023]);
      end
    end
    bus.host_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] rd, exp_rd, wd; logic err; int lat;
    logic we; logic [1:0] sel; logic [9:0] addr;
    for (int n = 0; n < 80; n++) begin
      sel  = 2'($urandom_range(0, 3));
      addr = ($urandom % 2 == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      wd   = 8'($urandom);
      we   = 1'($urandom);
      if (!we && sel != 2'd3 && !known[sel][addr]) we = 1'b1;
      exp_rd = (we || sel == 2'd3) ? 8'h00 : m[sel][addr];
      host_op(we, sel, addr, wd, rd, err, lat);
      if (we) model_write(sel, addr, wd);
      checks++;
      if (lat !== 2 || err !== (sel == 2'd3) || rd !== exp_rd) begin
        errors++;
        $display("FAIL random_host #%0d we=%b sel=%0d addr=%h: lat=%0d err=%b rdata=%h want lat=2 err=%b rdata=%h",
                 n, we, sel, addr, lat, err, rd, (sel == 2'd3), exp_rd);
      end
      if (sel < 2'd2 && known[sel][addr]) begin
        if (sel == 2'd0) bus.tp_sram_A_addr = addr; else bus.tp_sram_B_addr = addr;
        @(posedge clk); #1;
        checks++;
        if ((sel == 2'd0 ? bus.sram_A_dout : bus.sram_B_dout) !== m[sel][addr]) begin
          errors++;
          $display("FAIL random_tile #%0d bank=%0d addr=%h: got %h want %h", n, sel, addr,
                   (sel == 2'd0 ? bus.sram_A_dout : bus.sram_B_dout), m[sel][addr]);
        end
      end
    end
  endtask

`ifdef TILE_SRAM_PARITY_EN
  task automatic test_parity();
    logic [7:0] rd; logic err; int lat;
    host_op(1'b1, 2'd0, 10'h030, 8'h0F, rd, err, lat);
    dut.mem_a[48][0] = ~dut.mem_a[48][0];
    host_op(1'b0, 2'd0, 10'h030, 8'h00, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 8'h0E) begin
      errors++;
      $display("FAIL parity_host: err=%b rdata=%h want err=1 rdata=0e", err, rd);
    end
    bus.tp_sram_A_addr = 10'h030;
    @(posedge clk); #1;
    checks++;
    if (parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_tile_sticky: got %b want 1", parity_err);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_host_rw();
    test_tile_latency();
    test_busy();
    test_collision();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef TILE_SRAM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
